// File: rtl/pattern_detector_fsm_pkg.sv
// Shared types and constants for the serial 1-0-1-1 pattern detector.
// States are a 3-bit encoded enum; encodings 5..7 are unused and treated as illegal.
// The pattern is written with the first-received bit in the MSB.
package pattern_detector_fsm_pkg;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_1    = 3'd1,
      S_10   = 3'd2,
      S_101  = 3'd3,
      S_1011 = 3'd4
   } state_t;

   localparam logic [3:0] PATTERN     = 4'b1011;
   localparam int         PATTERN_LEN = 4;

endpackage

// File: rtl/pattern_detector_fsm.sv
// Moore FSM detecting the overlapping serial pattern 1,0,1,1 on stream_in.
// Latency: pattern_found is high for the cycle after the edge that samples the final 1.
// Backpressure: none; one bit is consumed every clock and the detector never stalls.
module pattern_detector_fsm
   import pattern_detector_fsm_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic stream_in,
   output logic pattern_found
);

   state_t state;
   state_t next_state;

   // State register; synchronous reset drops all partial-match history.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic; after a match the trailing 1 or 10 is kept for overlap.
   always_comb begin
      next_state = S_IDLE;
      case (state)
         S_IDLE:  next_state = stream_in ? S_1    : S_IDLE;
         S_1:     next_state = stream_in ? S_1    : S_10;
         S_10:    next_state = stream_in ? S_101  : S_IDLE;
         S_101:   next_state = stream_in ? S_1011 : S_10;
         S_1011:  next_state = stream_in ? S_1    : S_10;
         default: next_state = S_IDLE;
      endcase
   end

   // Output is a pure decode of the state register, so stream_in never reaches it combinationally.
   always_comb begin
      pattern_found = (state == S_1011);
   end

endmodule

// File: tb/tb_pattern_detector_fsm.sv
// Self-checking bench for pattern_detector_fsm: table of directed vectors plus
// hand-written sequences for reset/completion collision and a long reference-model stream.
module tb_pattern_detector_fsm;
   import pattern_detector_fsm_pkg::*;

   logic clk;
   logic rst;
   logic stream_in;
   logic pattern_found;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic rst;
      logic din;
      logic exp;
   } vec_t;

   vec_t vecs[$];

   localparam logic [32:0] LONG_STREAM = 33'h0B532F56B;

   pattern_detector_fsm dut (
      .clk           (clk),
      .rst           (rst),
      .stream_in     (stream_in),
      .pattern_found (pattern_found)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case the stimulus ever stalls.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required finish before limit");
      $fatal(1, "watchdog");
   end

   task automatic add(input logic r, input logic d, input logic e);
      vec_t v;
      v.rst = r;
      v.din = d;
      v.exp = e;
      vecs.push_back(v);
   endtask

   // Drive one bit away from the edge, clock it in, sample just after the edge.
   task automatic step(input logic r, input logic d);
      @(negedge clk);
      rst       = r;
      stream_in = d;
      @(posedge clk);
      #1;
   endtask

   task automatic check_found(input string name, input logic exp);
      checks++;
      if (pattern_found !== exp) begin
         failures++;
         $display("FAIL %s: pattern_found=%b required=%b", name, pattern_found, exp);
      end
   endtask

   task automatic check_idle(input string name);
      checks++;
      if (dut.state !== S_IDLE) begin
         failures++;
         $display("FAIL %s: state=%0d required=%0d", name, dut.state, S_IDLE);
      end
   endtask

   initial begin
      logic [3:0] hist;
      logic       exp;

      rst       = 1'b1;
      stream_in = 1'b0;

      // Reset held 10 cycles with stream_in=1
      for (int i = 0; i < 10; i++) add(1'b1, 1'b1, 1'b0);
      // Basic match, then one more bit drops the flag
      add(0,1,0); add(0,0,0); add(0,1,0); add(0,1,1); add(0,0,0);
      // Overlap 1,0,1,1,0,1,1
      add(1,0,0);
      add(0,1,0); add(0,0,0); add(0,1,0); add(0,1,1);
      add(0,0,0); add(0,1,0); add(0,1,1);
      // Near misses 1,0,0,1,1,1,0,1,0,1,1
      add(1,0,0);
      add(0,1,0); add(0,0,0); add(0,0,0); add(0,1,0); add(0,1,0); add(0,1,0);
      add(0,0,0); add(0,1,0); add(0,0,0); add(0,1,0); add(0,1,1);
      // Mid-pattern reset: 1,0,1, rst, 1 (no hit), then 0,1,1 (hit)
      add(1,0,0);
      add(0,1,0); add(0,0,0); add(0,1,0);
      add(1,0,0);
      add(0,1,0); add(0,0,0); add(0,1,0); add(0,1,1);

      foreach (vecs[i]) begin
         step(vecs[i].rst, vecs[i].din);
         check_found($sformatf("vec[%0d]", i), vecs[i].exp);
         if (vecs[i].rst) check_idle($sformatf("vec[%0d].state", i));
      end

      // Reset wins over a completion on the same edge
      step(1, 0);
      step(0, 1); step(0, 0); step(0, 1);
      step(1, 1);
      check_found("collide_found", 1'b0);
      check_idle("collide_state");
      // History discarded: next 1 starts fresh, no hit
      step(0, 1);
      check_found("collide_after", 1'b0);

      // Long stream, LSB first, against a 4-bit history model
      step(1, 0);
      hist = 4'b0000;
      for (int i = 0; i < 33; i++) begin
         step(0, LONG_STREAM[i]);
         hist = {hist[2:0], LONG_STREAM[i]};
         exp  = (hist == 4'b1011);
         check_found($sformatf("long[%0d]", i), exp);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
